exe_issue_arbiter: RTL and testbench
====================================

// Module: exe_issue_arbiter
// PURPOSE
//   Shares the single combinational execute unit (exe_stage) among NUM_REQ requesters. Round-robin grants one
//   request per cycle, drives opcode/operands to the execute unit, captures its result tagged with the requester
//   ID into a FIFO_DEPTH-entry response FIFO. Valid/ready handshakes on both sides give 1 op/cycle under no stall.
// PARAMETERS
//   NUM_REQ     4             number of requesters (>=2)
//   DATA_WIDTH  `DATA_WIDTH   operand/result width
//   FIFO_DEPTH  2             response FIFO entries (power of 2, >=2)
// PORTS
//   clk        in   1                    clock, all state on rising edge
//   rst        in   1                    reset, synchronous, active-high
//   req_valid  in   NUM_REQ              per-requester request valid
//   req_opcode in   NUM_REQ*8            packed opcodes, requester i at [8i+7:8i]
//   req_op1    in   NUM_REQ*DATA_WIDTH   packed operand 1
//   req_op2    in   NUM_REQ*DATA_WIDTH   packed operand 2
//   req_ready  out  NUM_REQ              one-hot grant; request i accepted when req_valid[i]&req_ready[i]
//   exe_opcode out  8                    to exe_stage inst_opcode (8'h0 when no grant)
//   exe_op1    out  DATA_WIDTH           to exe_stage op1 (0 when no grant)
//   exe_op2    out  DATA_WIDTH           to exe_stage op2 (0 when no grant)
//   exe_result in   DATA_WIDTH           from exe_stage rd_data, same cycle
//   rsp_valid  out  1                    response FIFO non-empty
//   rsp_id     out  $clog2(NUM_REQ)      requester index of head response
//   rsp_data   out  DATA_WIDTH           result of head response
//   rsp_ready  in   1                    consumer pops head when rsp_valid&rsp_ready
//   busy_cnt   out  32                   count of cycles with an accepted request (wraps at 2^32)
// BEHAVIOUR
//   Reset: rr_ptr=0, FIFO empty (rsp_valid=0, rsp_id=0, rsp_data=0), busy_cnt=0; req_ready=0 during reset cycle.
//   Accept enable: can_accept = !fifo_full | pop, pop = rsp_valid&rsp_ready (same-cycle pop frees a slot).
//   Arbitration (combinational): search req_valid starting at rr_ptr upward, wrap modulo NUM_REQ; first set
//     bit wins. req_ready = one-hot(winner) if can_accept & |req_valid, else 0. Never more than one bit set.
//   rr_ptr update: on accept of requester w, rr_ptr <= (w+1) mod NUM_REQ; unchanged otherwise.
//   Execute: granted request's opcode/operands muxed to exe_*; exe_result sampled same cycle and pushed with
//     id=w. Latency request-accept -> rsp_valid = 1 cycle (registered FIFO write, head visible next cycle).
//   FIFO: push on accept, pop on handshake; simultaneous push+pop when full is legal, count unchanged;
//     simultaneous push+pop when empty: pushed entry becomes head next cycle (no bypass). Pointers wrap mod
//     FIFO_DEPTH. Head outputs stable while rsp_valid&!rsp_ready.
//   Unknown opcode: forwarded as-is; exe_stage returns 0; response still produced.
//   Requester may drop req_valid without acceptance; no state retained for it.
//   busy_cnt increments on each accept, wraps 2^32-1 -> 0.
//   Reset mid-operation: FIFO contents discarded, in-flight responses lost, rr_ptr returns to 0.
// STRUCTURE
//   Shared package sys_defs: `DATA_WIDTH, `ZERO_WORD, `INST_* opcodes (existing); add typedef exe_rsp_t
//     {id, data} for FIFO entries.
//   Sub-module: rr_arbiter (NUM_REQ, req/ptr in, one-hot grant + encoded index out), reusable elsewhere.
//   FIFO inline (small register array + count); exe_stage instantiated by parent, not inside this block.
// TESTING
//   1 Single req: req_valid=4'b0010, INST_ADD, op1=5, op2=7, rsp_ready=1 -> req_ready=0010, next cycle
//     rsp_valid=1, rsp_id=1, rsp_data=12; busy_cnt=1.
//   2 All 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; responses in same order.
//   3 Backpressure: all valid, rsp_ready=0 -> exactly 2 accepts then req_ready=0; raise rsp_ready -> pops
//     and accepts resume same cycle (push+pop while full), no response lost or duplicated.
//   4 Fairness: req 0 always valid, req 3 valid from cycle 5 -> req 3 granted within NUM_REQ accepts.
//   5 Unknown opcode 8'hFF, op1=op2=1 -> response rsp_data=0 with correct rsp_id.
//   6 Assert rst with 2 responses queued -> next cycle rsp_valid=0, busy_cnt=0, first grant goes to req 0.

Source files
------------

// File: rtl/sys_defs.sv
// Shared core definitions: datapath width, opcodes and
// the response record used by the execute issue arbiter.
package sys_defs;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;

  localparam logic [7:0] INST_ADD = 8'h01;
  localparam logic [7:0] INST_SUB = 8'h02;
  localparam logic [7:0] INST_AND = 8'h03;
  localparam logic [7:0] INST_OR  = 8'h04;
  localparam logic [7:0] INST_XOR = 8'h05;

  // Wide enough for any practical requester count
  localparam int MAX_ID_W = 8;

  typedef struct packed {
    logic [MAX_ID_W-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
  } exe_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr,
// wrapping modulo N, wins a one-hot grant.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr_i) + i) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/exe_issue_arbiter.sv
// Shares one combinational execute unit among requesters,
// queueing tagged results in a small response FIFO.
module exe_issue_arbiter
  import sys_defs::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = sys_defs::DATA_WIDTH,
  parameter int FIFO_DEPTH = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*8-1:0]          req_opcode,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [7:0]                    exe_opcode,
  output logic [DATA_WIDTH-1:0]         exe_op1,
  output logic [DATA_WIDTH-1:0]         exe_op2,
  input  logic [DATA_WIDTH-1:0]         exe_result,
  output logic                          rsp_valid,
  output logic [IW-1:0]                 rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic                          rsp_ready,
  output logic [31:0]                   busy_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [IW-1:0]      rr_ptr_q, rr_ptr_d, win;
  logic [NUM_REQ-1:0] gnt;
  logic               any;
  logic               full, pop, accept;
  exe_rsp_t           rsp_in;
  exe_rsp_t           mem_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_q, rd_q;
  logic [PW:0]        cnt_q, cnt_d;
  logic [31:0]        busy_cnt_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any)
  );

  // A same-cycle pop frees the slot the push needs
  assign rsp_valid = (cnt_q != '0);
  assign full      = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop       = rsp_valid & rsp_ready;
  assign accept    = !rst & (!full | pop) & any;
  assign req_ready = accept ? gnt : '0;

  always_comb begin
    exe_opcode = '0;
    exe_op1    = '0;
    exe_op2    = '0;
    if (accept) begin
      exe_opcode = req_opcode[8*win +: 8];
      exe_op1    = req_op1[DATA_WIDTH*win +: DATA_WIDTH];
      exe_op2    = req_op2[DATA_WIDTH*win +: DATA_WIDTH];
    end
    rsp_in      = '0;
    rsp_in.id   = MAX_ID_W'(win);
    rsp_in.data = exe_result;
  end

  assign rr_ptr_d = (win == IW'(NUM_REQ-1)) ? '0
                                            : win + 1'b1;
  assign cnt_d    = cnt_q + (PW+1)'(accept)
                          - (PW+1)'(pop);

  assign rsp_id   = rsp_valid ? mem_q[rd_q].id[IW-1:0] : '0;
  assign rsp_data = rsp_valid ? mem_q[rd_q].data : '0;
  assign busy_cnt = busy_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (accept) begin
        rr_ptr_q   <= rr_ptr_d;
        wr_q       <= wr_q + 1'b1;
        busy_cnt_q <= busy_cnt_q + 32'd1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: outputs are masked when empty
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= rsp_in;
  end

endmodule

// File: tb/tb_exe_issue_arbiter.sv
// Directed bench for exe_issue_arbiter with a small
// behavioural execute unit closing the loop.
module tb_exe_issue_arbiter;
  import sys_defs::*;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_opcode;
  logic [N*W-1:0] req_op1, req_op2;
  logic [N-1:0]   req_ready;
  logic [7:0]     exe_opcode;
  logic [W-1:0]   exe_op1, exe_op2, exe_result;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_ready;
  logic [31:0]    busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] g2 [5] = '{4'b0100, 4'b1000, 4'b0001,
                         4'b0010, 4'b0100};
  int id2 [5] = '{2, 3, 0, 1, 2};
  int dt2 [5] = '{22, 33, 0, 11, 22};

  exe_issue_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(W), .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_opcode (req_opcode),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_ready  (req_ready),
    .exe_opcode (exe_opcode),
    .exe_op1    (exe_op1),
    .exe_op2    (exe_op2),
    .exe_result (exe_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    exe_result = '0;
    case (exe_opcode)
      INST_ADD: exe_result = exe_op1 + exe_op2;
      INST_SUB: exe_result = exe_op1 - exe_op2;
      INST_AND: exe_result = exe_op1 & exe_op2;
      INST_OR:  exe_result = exe_op1 | exe_op2;
      INST_XOR: exe_result = exe_op1 ^ exe_op2;
      default:  exe_result = '0;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input int id,
                         input int data);
    chk({tag, "_v"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_id"}, 64'(rsp_id), 64'(id));
    chk({tag, "_d"}, 64'(rsp_data), 64'(data));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setr(input int i, input logic [7:0] op,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b);
    req_opcode[8*i +: 8] = op;
    req_op1[W*i +: W]    = a;
    req_op2[W*i +: W]    = b;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_opcode = '0;
    req_op1    = '0;
    req_op2    = '0;
    rsp_ready  = 1'b0;

    // reset
    tick;
    req_valid = 4'hF;
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    tick;
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_rv", 64'(rsp_valid), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_data", 64'(rsp_data), 64'd0);
    chk("rst_busy", 64'(busy_cnt), 64'd0);

    // single request
    setr(1, INST_ADD, 32'd5, 32'd7);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    chk("t1_ready", 64'(req_ready), 64'b0010);
    chk("t1_opc", 64'(exe_opcode), 64'h01);
    chk("t1_op1", 64'(exe_op1), 64'd5);
    chk("t1_op2", 64'(exe_op2), 64'd7);
    tick;
    req_valid = '0;
    #1;
    chk_rsp("t1_rsp", 1, 12);
    chk("t1_busy", 64'(busy_cnt), 64'd1);
    chk("t1_idle_opc", 64'(exe_opcode), 64'h0);
    tick;
    #1;
    chk("t1_drain", 64'(rsp_valid), 64'd0);

    // all valid, streaming; pointer starts at 2
    for (int i = 0; i < N; i++)
      setr(i, INST_ADD, W'(10 * i), W'(i));
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t2_g%0d", c), 64'(req_ready),
          64'(g2[c]));
      if (c > 0)
        chk_rsp($sformatf("t2_r%0d", c - 1),
                id2[c-1], dt2[c-1]);
      tick;
    end
    req_valid = '0;
    #1;
    chk_rsp("t2_r4", id2[4], dt2[4]);
    chk("t2_busy", 64'(busy_cnt), 64'd6);
    tick;
    #1;
    chk("t2_drain", 64'(rsp_valid), 64'd0);

    // backpressure; pointer at 3
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("t3_g0", 64'(req_ready), 64'b1000);
    tick;
    #1;
    chk("t3_g1", 64'(req_ready), 64'b0001);
    chk_rsp("t3_h1", 3, 33);
    tick;
    #1;
    chk("t3_full0", 64'(req_ready), 64'b0000);
    chk_rsp("t3_h2", 3, 33);
    tick;
    #1;
    chk("t3_full1", 64'(req_ready), 64'b0000);
    rsp_ready = 1'b1;
    #1;
    chk("t3_pushpop", 64'(req_ready), 64'b0010);
    chk_rsp("t3_h3", 3, 33);
    tick;
    #1;
    chk("t3_g4", 64'(req_ready), 64'b0100);
    chk_rsp("t3_h4", 0, 0);
    tick;
    req_valid = '0;
    #1;
    chk_rsp("t3_h5", 1, 11);
    tick;
    #1;
    chk_rsp("t3_h6", 2, 22);
    tick;
    #1;
    chk("t3_drain", 64'(rsp_valid), 64'd0);
    chk("t3_busy", 64'(busy_cnt), 64'd10);

    // fairness: req 0 hogs, req 3 joins later
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t4_g%0d", c), 64'(req_ready),
          64'b0001);
      tick;
    end
    req_valid = 4'b1001;
    #1;
    chk("t4_req3", 64'(req_ready), 64'b1000);
    tick;
    #1;
    chk("t4_back0", 64'(req_ready), 64'b0001);
    tick;
    req_valid = '0;
    tick;
    tick;
    #1;
    chk("t4_busy", 64'(busy_cnt), 64'd17);

    // unknown opcode
    setr(2, 8'hFF, 32'd1, 32'd1);
    req_valid = 4'b0100;
    #1;
    chk("t5_ready", 64'(req_ready), 64'b0100);
    chk("t5_opc", 64'(exe_opcode), 64'hFF);
    tick;
    req_valid = '0;
    #1;
    chk_rsp("t5_rsp", 2, 0);
    chk("t5_busy", 64'(busy_cnt), 64'd18);
    tick;

    // reset with two responses queued; pointer at 3
    for (int i = 0; i < N; i++)
      setr(i, INST_ADD, W'(10 * i), W'(i));
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("t6_g0", 64'(req_ready), 64'b1000);
    tick;
    #1;
    chk("t6_g1", 64'(req_ready), 64'b0001);
    tick;
    #1;
    chk("t6_full", 64'(req_ready), 64'b0000);
    chk_rsp("t6_head", 3, 33);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("t6_rv", 64'(rsp_valid), 64'd0);
    chk("t6_id", 64'(rsp_id), 64'd0);
    chk("t6_data", 64'(rsp_data), 64'd0);
    chk("t6_busy", 64'(busy_cnt), 64'd0);
    chk("t6_g", 64'(req_ready), 64'b0001);
    rsp_ready = 1'b1;
    tick;
    req_valid = '0;
    #1;
    chk_rsp("t6_rsp", 0, 0);
    tick;
    #1;
    chk("t6_drain", 64'(rsp_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
